// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - command-driven dot-product sequencer in front of a MAC unit
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   cmd_valid/ready, cmd_len  length command (number of operand pairs, 0 allowed)
//   op_valid/ready, op_a/b    operand pair stream
//   mac_en/clr, mac_a/b       drive the MAC's En/Clr/Ain/Bin
//   mac_cout                  MAC accumulated output (combinational in the MAC)
//   res_valid/ready, res_data dot-product result
//   busy                      high whenever not IDLE
module mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [3*DATA_WIDTH-1:0] res_q;

  logic cmd_fire;
  logic op_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign op_fire  = op_valid && op_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Remaining-pair counter and captured result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      res_q     <= '0;
    end else begin
      if (state == IDLE && cmd_fire) begin
        remaining <= cmd_len;
      end else if (state == STREAM && op_fire) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
      // The last beat was registered by the MAC at the previous edge, so
      // mac_cout already carries the complete sum during DRAIN.
      if (state == DRAIN) begin
        res_q <= mac_cout;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_fire) next_state = CLEAR;
      CLEAR:   next_state = (remaining != '0) ? STREAM : DRAIN;
      STREAM:  if (op_fire && remaining == LEN_WIDTH'(1)) next_state = DRAIN;
      DRAIN:   next_state = RESULT;
      RESULT:  if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs; mac_en and mac_clr are decoded from disjoint states so they
  // can never be high together.
  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    op_ready  = (state == STREAM);
    mac_en    = (state == STREAM) && op_valid;
    mac_clr   = (state == CLEAR);
    mac_a     = (state == STREAM) ? op_a : '0;
    mac_b     = (state == STREAM) ? op_b : '0;
    res_valid = (state == RESULT);
    busy      = (state != IDLE);
  end

  assign res_data = res_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - self-checking bench for mac_seq with a behavioural MAC
module tb_mac_seq;

  localparam int DW = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [3*DW-1:0] mac_cout;
  logic          res_valid;
  logic          res_ready;
  logic [3*DW-1:0] res_data;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int qa[$];
  int qb[$];

  // Stale contents: the MAC is not cleared by reset, only by CLEAR.
  logic [3*DW-1:0] acc = 24'h5A5A5A;

  always #5 clk = ~clk;

  mac_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // Behavioural MAC: registers the product into the accumulator on En.
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + (24'(mac_a) * 24'(mac_b));
  end
  assign mac_cout = acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Interface invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mac_en) en_cnt++;
      if (mac_clr) clr_cnt++;
      check("en_clr_exclusive", {63'd0, mac_en && mac_clr}, 64'd0);
      if (!op_ready) check("idle_mac_outputs", {47'd0, mac_en, mac_a, mac_b}, 64'd0);
    end
  end

  // Runs one command using the pairs in qa/qb. gap<0 selects random gaps.
  task automatic do_cmd(input int n, input int gap, input int hold);
    int cyc, idx, gap_left, t, vcyc;
    longint s;
    logic [3*DW-1:0] exp, held;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(qa[i]) * longint'(qb[i]);
    exp = 24'(s % (longint'(1) << 24));
    t = 0;
    while (!cmd_ready && t < 50) begin @(posedge clk); #2; t++; end
    check("cmd_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_len   = LW'(n);
    op_valid  = 1'b0;
    res_ready = (hold == 0);
    en_cnt  = 0;
    clr_cnt = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1; idx = 0; gap_left = 0; vcyc = -1;
    while (cyc < 2000) begin
      if (idx < n && gap_left == 0) begin
        op_valid = 1'b1;
        op_a = DW'(qa[idx]);
        op_b = DW'(qb[idx]);
      end else begin
        op_valid = 1'b0;
      end
      #1;
      if (res_valid) begin vcyc = cyc; break; end
      if (op_valid && op_ready) begin
        idx++;
        gap_left = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      @(posedge clk); #1;
      cyc++;
    end
    op_valid = 1'b0;
    check("res_valid_seen", {63'd0, vcyc >= 0}, 64'd1);
    if (gap == 0) check("res_latency", 64'(vcyc), 64'(n + 3));
    check("res_data", 64'(res_data), 64'(exp));
    check("mac_en_cycles", 64'(en_cnt), 64'(n));
    check("mac_clr_pulses", 64'(clr_cnt), 64'd1);
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_len   = LW'(1);
      @(posedge clk); #2;
      check("hold_res_valid", {63'd0, res_valid}, 64'd1);
      check("hold_res_data", 64'(res_data), 64'(held));
      check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b0;
    check("idle_after_handshake", {62'd0, busy, cmd_ready}, 64'd1);
  endtask

  task automatic fill_random(input int n);
    qa = {}; qb = {};
    for (int i = 0; i < n; i++) begin
      qa.push_back(int'($urandom_range(0, 255)));
      qb.push_back(int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    #12;
    check("reset_outputs",
          {45'd0, cmd_ready, op_ready, mac_en, mac_clr, res_valid, busy, mac_a, mac_b}, 64'd0);
    check("reset_res_data", 64'(res_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    check("cmd_ready_after_reset", {63'd0, cmd_ready}, 64'd1);
    check("busy_after_reset", {63'd0, busy}, 64'd0);

    // Basic sum
    qa = {1, 3, 5}; qb = {2, 4, 6};
    do_cmd(3, 0, 0);

    // Empty command
    qa = {}; qb = {};
    do_cmd(0, 0, 0);

    // Gapped operands
    qa = {255, 255}; qb = {255, 255};
    do_cmd(2, 3, 0);

    // Backpressure; the presented next command is accepted by the following call
    fill_random(4);
    do_cmd(4, 0, 5);
    fill_random(2);
    do_cmd(2, 0, 0);

    // Reset mid-stream after two accepted beats
    fill_random(4);
    cmd_valid = 1'b1; cmd_len = LW'(4);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = DW'(qa[0]); op_b = DW'(qb[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    op_a = DW'(qa[1]); op_b = DW'(qb[1]);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {45'd0, cmd_ready, op_ready, mac_en, mac_clr, res_valid, busy, mac_a, mac_b}, 64'd0);
    check("async_reset_res_data", 64'(res_data), 64'd0);
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("cmd_ready_after_mid_reset", {63'd0, cmd_ready}, 64'd1);
    qa = {7}; qb = {7};
    do_cmd(1, 0, 0);

    // Random commands
    for (int k = 0; k < 4; k++) begin
      int n;
      n = int'($urandom_range(1, 20));
      fill_random(n);
      do_cmd(n, -1, int'($urandom_range(0, 3)));
    end

    // Wrap-around
    qa = {}; qb = {};
    for (int i = 0; i < 300; i++) begin qa.push_back(255); qb.push_back(255); end
    do_cmd(300, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Command-driven dot-product sequencer that sits in front of a MAC unit.
- Accepts a length command, streams operand pairs into the MAC's En/Clr/Ain/Bin interface, captures the MAC's accumulated Cout and returns it on a valid/ready result port.
- Guarantees the MAC is cleared before every dot product and is never given En and Clr together.

Parameters:
DATA_WIDTH  8  operand width; the result is 3*DATA_WIDTH, matching the MAC
LEN_WIDTH   8  width of the command length field (max pairs per command = 2^LEN_WIDTH-1)

Ports:
clk        input   1               clock; all logic on rising edge
rst        input   1               asynchronous, active-high reset
cmd_valid  input   1               command valid
cmd_ready  output  1               command accepted when valid&ready
cmd_len    input   LEN_WIDTH       number of operand pairs (0 allowed)
op_valid   input   1               operand pair valid
op_ready   output  1               operand pair accepted when valid&ready
op_a       input   DATA_WIDTH      operand A
op_b       input   DATA_WIDTH      operand B
mac_en     output  1               to MAC En
mac_clr    output  1               to MAC Clr
mac_a      output  DATA_WIDTH      to MAC Ain
mac_b      output  DATA_WIDTH      to MAC Bin
mac_cout   input   3*DATA_WIDTH    from MAC Cout; combinational accum+mult
res_valid  output  1               result valid
res_ready  input   1               result accepted when valid&ready
res_data   output  3*DATA_WIDTH    dot-product result
busy       output  1               high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE. The remaining-pair counter and res_data clear to 0.
  - All outputs are 0 except cmd_ready, which is 1 once rst deasserts.
  - The MAC is not cleared by reset. Stale MAC contents are removed by the CLEAR state of the next command.
- FSM states are IDLE, CLEAR, STREAM, DRAIN and RESULT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_len into the remaining-pair counter and go to CLEAR.
- CLEAR:
  - Lasts exactly one cycle with mac_clr=1 and mac_en=0.
  - Next state is STREAM if the latched length is nonzero, otherwise DRAIN.
- STREAM:
  - op_ready=1.
  - mac_en = op_valid (a beat is accepted only when op_valid&op_ready).
  - mac_a=op_a and mac_b=op_b, passed through combinationally; the MAC registers them.
  - Each accepted beat decrements the counter.
  - When the final beat is accepted (counter==1 and beat accepted), go to DRAIN.
  - op_valid gaps are allowed: mac_en stays 0 and the counter holds.
- DRAIN:
  - Lasts one cycle with mac_en=0 and mac_clr=0.
  - mac_cout already holds the full sum. res_data <= mac_cout at the end of this cycle; go to RESULT.
- RESULT:
  - res_valid=1 and res_data is held stable.
  - On res_ready, go to IDLE.
  - res_valid must not drop, and res_data must not change, until the handshake completes.
- Outside STREAM: op_ready=0, mac_en=0, mac_a=0, mac_b=0.
- Outside CLEAR: mac_clr=0.
- mac_en and mac_clr are never high in the same cycle.
- cmd_ready is high only in IDLE. A command presented in any other state waits.
- Latency with op_valid held high, with the command accepted at edge 0:
  - mac_clr is high in cycle 1.
  - Beats are accepted in cycles 2..N+1.
  - DRAIN is cycle N+2.
  - res_valid rises in cycle N+3.
  - For N=0, res_valid rises in cycle 3.
- Arithmetic: no saturation. The result wraps modulo 2^(3*DATA_WIDTH), exactly as the MAC accumulates.
- Reset asserted mid-operation: immediately abandons the command. Partially accumulated MAC state is discarded at the next CLEAR.
- busy is low only in IDLE.

Test Plan:
1. Basic sum: cmd_len=3, pairs (1,2),(3,4),(5,6) back-to-back, res_ready=1 -> res_data=44; res_valid 6 cycles after cmd accept; exactly one mac_clr pulse; exactly 3 mac_en cycles.
2. Empty command: cmd_len=0 -> mac_en never high; res_data=0; res_valid in cycle 3 after accept.
3. Gapped operands: cmd_len=2, pairs (255,255),(255,255) with 3 idle cycles between them -> res_data=130050; mac_en high only on accepted beats; the counter holds during gaps.
4. Backpressure: hold res_ready=0 for 5 cycles in RESULT while presenting a new command -> res_valid and res_data stay stable; cmd_ready=0; the new command is accepted only in the cycle after res_ready handshakes.
5. Reset mid-STREAM: cmd_len=4, assert rst after 2 beats -> all outputs 0 asynchronously and state IDLE; then cmd_len=1, pair (7,7) -> res_data=49, so stale products are not included.
6. Wrap-around: DATA_WIDTH=8, LEN_WIDTH=9, cmd_len=300, all pairs (255,255) -> res_data=2730284 (19507500 mod 2^24); no flag and no stall.
